// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a COUNT / DATA / CHK byte frame from a
// valid/ready byte link and writes each assembled little-endian word into imem.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int BPW = N / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  MAX_COUNT = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [BW-1:0] byteIdx_q, byteIdx_d;
  logic [AW:0]   words_q, words_d;
  logic [7:0]    chk_q, chk_d;
  logic          err_q, err_d;

  logic accept;
  logic lastByte;
  logic lastWord;
  logic countErr;

  assign accept   = rx_valid & rx_ready;
  assign lastByte = (byteIdx_q == BW'(BPW - 1));
  assign lastWord = (({1'b0, waddr_q} + {{AW{1'b0}}, 1'b1}) == words_q);
  assign countErr = (rx_data > MAX_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start)  state_d = S_COUNT;
      S_COUNT:        if (accept) state_d = countErr ? S_DONE : S_DATA;
      S_DATA:         if (accept && lastByte) state_d = S_WRITE;
      S_WRITE:        state_d = lastWord ? S_CHECK : S_DATA;
      S_CHECK:        if (accept) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    we       = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_COUNT, S_DATA, S_CHECK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_WRITE: begin
        we       = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;

  // Datapath: word assembly, running XOR checksum and word-address walk.
  always_comb begin
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    byteIdx_d = byteIdx_q;
    words_d   = words_q;
    chk_d     = chk_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          waddr_d   = '0;
          byteIdx_d = '0;
          chk_d     = '0;
          err_d     = 1'b0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          words_d = (rx_data == 8'd0) ? MAX_WORDS : rx_data[AW:0];
          chk_d   = rx_data;
          err_d   = countErr;
        end
      end
      S_DATA: begin
        if (accept) begin
          for (int k = 0; k < BPW; k++) begin
            if (byteIdx_q == BW'(k)) wdata_d[8*k +: 8] = rx_data;
          end
          chk_d     = chk_q ^ rx_data;
          byteIdx_d = byteIdx_q + BW'(1);
        end
      end
      S_WRITE: begin
        if (!lastWord) begin
          waddr_d   = waddr_q + AW'(1);
          byteIdx_d = '0;
        end
      end
      S_CHECK: begin
        if (accept) err_d = (rx_data != chk_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_q   <= '0;
      wdata_q   <= '0;
      byteIdx_q <= '0;
      words_q   <= '0;
      chk_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      byteIdx_q <= byteIdx_d;
      words_q   <= words_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
    end
  end

endmodule
